// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority request arbiter with registered one-hot grant.
// Define RR_ARBITER_TIMEOUT_EN to add a hold-timeout that pre-empts long grants.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int IDW = $clog2(N);
  localparam logic [N-1:0] GNT_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IDW:0] N_W     = (IDW+1)'(N);

  if (N < 2 || N > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
    $error("rr_arbiter: N must be 2..16 and MAX_HOLD 1..255");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_nxt;
  logic [N-1:0]   gnt_q, gnt_nxt;
  logic [IDW-1:0] gnt_id_q, gnt_id_nxt;
  logic [IDW-1:0] last_id_q, last_id_nxt;

  logic [N-1:0]   cand;
  logic [IDW:0]   start_w, scan_w;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic           take, drop;

`ifdef RR_ARBITER_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_nxt;
  logic       expired;
  assign expired = (hold_cnt_q == 8'(MAX_HOLD));
`endif

  // The holder is never a candidate: it is either releasing or being pre-empted.
  always_comb begin
    cand = req;
    if (state_q == BUSY) cand[gnt_id_q] = 1'b0;
  end

  // Circular scan from the pointer; fixed priority always starts at index 0.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_w    = '0;
    start_w   = '0;
    if (RR_MODE != 0) begin
      start_w = {1'b0, last_id_q} + (IDW+1)'(1);
      if (start_w >= N_W) start_w = start_w - N_W;
    end
    for (int k = 0; k < N; k++) begin
      scan_w = start_w + (IDW+1)'(k);
      if (scan_w >= N_W) scan_w = scan_w - N_W;
      if (!win_found && cand[scan_w[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_w[IDW-1:0];
      end
    end
  end

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state_q;
    gnt_nxt     = gnt_q;
    gnt_id_nxt  = gnt_id_q;
    last_id_nxt = last_id_q;
    take        = 1'b0;
    drop        = 1'b0;
    case (state_q)
      IDLE: take = win_found;
      BUSY: begin
        if (!req[gnt_id_q]) begin
          take = win_found;
          drop = !win_found;
        end
`ifdef RR_ARBITER_TIMEOUT_EN
        else if (expired && win_found) begin
          take = 1'b1;
        end
`endif
      end
      default: drop = 1'b1;
    endcase

    if (take) begin
      state_nxt   = BUSY;
      gnt_nxt     = GNT_ONE << win_id;
      gnt_id_nxt  = win_id;
      last_id_nxt = win_id;
    end else if (drop) begin
      state_nxt  = IDLE;
      gnt_nxt    = '0;
      gnt_id_nxt = '0;
    end
  end

`ifdef RR_ARBITER_TIMEOUT_EN
  always_comb begin
    hold_cnt_nxt = hold_cnt_q;
    if (take || drop)                       hold_cnt_nxt = '0;
    else if (state_q == BUSY && !expired)   hold_cnt_nxt = hold_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_nxt;
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      last_id_q <= IDW'(N - 1);
    end else begin
      state_q   <= state_nxt;
      gnt_q     <= gnt_nxt;
      gnt_id_q  <= gnt_id_nxt;
      last_id_q <= last_id_nxt;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == BUSY);
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: a round-robin and a fixed-priority instance
// share one request vector and are compared against an abstract grant model.
module tb_rr_arbiter;

  localparam int NR = 4;
  localparam int MH = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] gnt_rr, gnt_fp;
  logic          gv_rr, gv_fp;
  logic [1:0]    gid_rr, gid_fp;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per instance: 0 = round-robin, 1 = fixed priority.
  int holder [2];
  int last   [2];
  int cnt    [2];

  always #5 clk = ~clk;

  rr_arbiter #(.N(NR), .RR_MODE(1), .MAX_HOLD(MH)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_rr), .gnt_valid(gv_rr), .gnt_id(gid_rr));

  rr_arbiter #(.N(NR), .RR_MODE(0), .MAX_HOLD(MH)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_fp), .gnt_valid(gv_fp), .gnt_id(gid_fp));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else             n_pass++;
  endtask

  function automatic bit bit_of(input logic [NR-1:0] r, input int i);
    return ((r >> i) & 4'd1) != 4'd0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      holder[m] = -1;
      last[m]   = NR - 1;
      cnt[m]    = 0;
    end
  endtask

  // A new winner is chosen when idle, when the holder lets go, or on timeout.
  task automatic model_step(input int m, input logic [NR-1:0] r);
    bit rel, pre;
    int w;
    rel = (holder[m] >= 0) && !bit_of(r, holder[m]);
    pre = 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
    if (holder[m] >= 0 && bit_of(r, holder[m]) && cnt[m] == MH)
      for (int j = 0; j < NR; j++)
        if (j != holder[m] && bit_of(r, j)) pre = 1'b1;
`endif
    if (holder[m] < 0 || rel || pre) begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        int c;
        c = (m == 0) ? (last[m] + 1 + k) % NR : k;
        if (w < 0 && bit_of(r, c) && c != holder[m]) w = c;
      end
      if (w >= 0) begin
        holder[m] = w;
        last[m]   = w;
        cnt[m]    = 0;
      end else begin
        holder[m] = -1;
      end
    end else if (holder[m] >= 0 && cnt[m] < MH) begin
      cnt[m]++;
    end
  endtask

  task automatic compare_all();
    logic [NR-1:0] eg;
    int            eid;
    for (int m = 0; m < 2; m++) begin
      eg  = (holder[m] >= 0) ? (4'b0001 << holder[m]) : 4'b0000;
      eid = (holder[m] >= 0) ? holder[m] : 0;
      if (m == 0) begin
        check("rr_gnt", gnt_rr, eg);
        check("rr_valid", gv_rr, holder[m] >= 0);
        check("rr_id", gid_rr, eid);
        check("rr_onehot0", $onehot0(gnt_rr), 1);
      end else begin
        check("fp_gnt", gnt_fp, eg);
        check("fp_valid", gv_fp, holder[m] >= 0);
        check("fp_id", gid_fp, eid);
        check("fp_onehot0", $onehot0(gnt_fp), 1);
      end
    end
  endtask

  // Drive at the falling edge, let both DUTs and models advance, check after.
  task automatic tick(input logic [NR-1:0] r);
    @(negedge clk);
    rst_n = 1'b1;
    req   = r;
    @(posedge clk);
    model_step(0, r);
    model_step(1, r);
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
  endtask

  int order [5] = '{0, 1, 2, 3, 0};
  int wait_cnt [NR];
  int max_wait;
  logic [NR-1:0] prev_gnt, r;

  initial begin
    apply_reset();

    // Release, then hand-over with no idle cycle.
    tick(4'b0101);
    check("r029_gnt0", gnt_rr, 4'b0001);
    check("r029_id0", gid_rr, 0);
    tick(4'b0100);
    check("r029_gnt2", gnt_rr, 4'b0100);
    check("r029_id2", gid_rr, 2);

    // All requesting; each holder releases for one cycle after two.
    apply_reset();
    tick(4'b1111);
    check("r030_first", gnt_rr, 4'b0001);
    for (int g = 0; g < 4; g++) begin
      tick(4'b1111);
      check("r030_hold", gnt_rr, 4'b0001 << order[g]);
      tick(4'b1111 & ~(4'b0001 << order[g]));
      check("r030_next", gnt_rr, 4'b0001 << order[g+1]);
    end

    // Fixed priority: releasing requester is excluded, then priority returns.
    apply_reset();
    tick(4'b0011);
    check("r031_a", gnt_fp, 4'b0001);
    tick(4'b0010);
    check("r031_b", gnt_fp, 4'b0010);
    tick(4'b0011);
    check("r031_hold", gnt_fp, 4'b0010);
    tick(4'b0001);
    check("r031_c", gnt_fp, 4'b0001);

    // Asynchronous reset mid-grant, then pointer restarts from index 0.
    apply_reset();
    tick(4'b0101);
    check("r032_pre", gnt_rr, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("r032_async_gnt", gnt_rr, 4'b0000);
    check("r032_async_valid", gv_rr, 1'b0);
    check("r032_async_id", gid_rr, 0);
    model_reset();
    tick(4'b1000);
    check("r032_post", gnt_rr, 4'b1000);
    check("r032_post_id", gid_rr, 3);

`ifdef RR_ARBITER_TIMEOUT_EN
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      tick(4'b0011);
      check("r033_hold0", gnt_rr, 4'b0001);
    end
    tick(4'b0011);
    check("r033_preempt", gnt_rr, 4'b0010);
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      tick(4'b0001);
      check("r033_alone", gnt_rr, 4'b0001);
    end
`else
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      tick(4'b0011);
      check("r028_hold", gnt_rr, 4'b0001);
    end
`endif

    // Randomized traffic; holders tend to keep requesting for a while.
    apply_reset();
    max_wait = 0;
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    prev_gnt = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r = NR'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      if (holder[0] >= 0 && $urandom_range(0, 3) != 0) r = r | (4'b0001 << holder[0]);
      tick(r);
      for (int i = 0; i < NR; i++) begin
        if (!r[i] || gnt_rr[i])                      wait_cnt[i] = 0;
        else if (gnt_rr != prev_gnt && gnt_rr != '0) wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      prev_gnt = gnt_rr;
    end
    check("no_starvation", max_wait <= NR, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, legal range 2..16.
REQ-002 SHALL have parameter RR_MODE, default 1: 1 = round-robin priority, 0 = fixed priority (index 0 highest).
REQ-003 SHALL have parameter MAX_HOLD, default 16: hold-timeout in cycles, legal range 1..255, used only when RR_ARBITER_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, N bits: request vector, bit i from requester i, level-sensitive.
REQ-007 SHALL have port gnt, output, N bits: registered one-hot grant, or all-zero.
REQ-008 SHALL have port gnt_valid, output, 1 bit: high when gnt is non-zero.
REQ-009 SHALL have port gnt_id, output, clog2(N) bits: index of the granted requester, 0 when gnt_valid is low.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and BUSY (one grant held).
REQ-011 SHALL, in IDLE with req non-zero, select a winner and enter BUSY with gnt driven at the next rising edge (1-cycle latency).
REQ-012 SHALL remain in IDLE with gnt zero while req is zero.
REQ-013 SHALL, in BUSY, hold the grant unchanged while req[gnt_id] stays high, regardless of other requests.
REQ-014 SHALL, in BUSY when req[gnt_id] is low, move the grant at the next edge directly to a new winner among the other requests, with no idle cycle.
REQ-015 SHALL, in the same case as REQ-014 with no other request pending, return to IDLE with gnt zero at the next edge.
REQ-016 SHALL, with RR_MODE=1, search from index (last_id+1) mod N upward with wrap-around; last_id is the most recently granted index, reset value N-1.
REQ-017 SHALL, with RR_MODE=0, grant the lowest-index active request.
REQ-018 SHALL exclude the releasing requester from selection in the cycle it releases, even with RR_MODE=0.
REQ-019 SHALL ignore a request that rises and falls between edges.
REQ-020 SHALL keep gnt, gnt_valid and gnt_id mutually consistent in every cycle.
REQ-021 SHALL never assert more than one gnt bit.

Reset
REQ-022 SHALL, on rst_n low, immediately force: state IDLE, gnt zero, gnt_valid 0, gnt_id 0, last_id N-1, hold counter 0.
REQ-023 SHALL, on reset during BUSY, drop the grant asynchronously without waiting for a clock edge.
REQ-024 SHALL evaluate its first arbitration at the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with macro RR_ARBITER_TIMEOUT_EN defined, include a hold counter that clears on every new grant and increments each BUSY cycle, saturating at MAX_HOLD.
REQ-026 SHALL, with RR_ARBITER_TIMEOUT_EN defined, when the counter equals MAX_HOLD and another request is pending, pre-empt the grant at the next edge to the next winner under the REQ-016/017 rules, excluding the current holder.
REQ-027 SHALL, with RR_ARBITER_TIMEOUT_EN defined, keep the grant and a saturated counter when the counter equals MAX_HOLD and no other request is pending.
REQ-028 SHALL, without RR_ARBITER_TIMEOUT_EN, contain no counter logic and hold grants indefinitely per REQ-013.

Verification (N=4, RR_MODE=1 unless stated)
REQ-029 SHALL cover: reset release, then req=4'b0101 -> gnt=4'b0001 and gnt_id=0 one cycle later; drop req[0] -> gnt=4'b0100 at the next edge, with no zero cycle.
REQ-030 SHALL cover: req=4'b1111 held, each holder dropping after 2 cycles and re-raising -> grant order 0,1,2,3,0 with no idle cycles.
REQ-031 SHALL cover: RR_MODE=0, req=4'b0011, req[0] released and re-raised each grant -> grants alternate 0,1,0 per REQ-018.
REQ-032 SHALL cover: rst_n low mid-grant -> gnt=0 before the next edge; after release with req=4'b1000 -> gnt=4'b1000 (search starts at 0, first match index 3).
REQ-033 SHALL cover: TIMEOUT_EN, MAX_HOLD=3, req=4'b0011 held -> grant 0 for 4 cycles, then grant 1; with req=4'b0001 only -> grant 0 held indefinitely.
REQ-034 SHALL cover: randomized req for 10k cycles -> assertions on REQ-020, REQ-021, and no starvation beyond N grant periods.
